// File: rtl/trap_ctrl.sv
// trap_ctrl: selects one exception cause from the execute/memory-stage
// detectors and records it in mepc/mcause/mtval. Handles mret. After a trap
// or mret is accepted, it holds flush for FLUSH_CYCLES cycles and then issues
// a one-cycle fetch redirect. It also owns the trap CSRs and their
// software read/write port.
//
// Ports:
//   i_clk, i_reset              clock, asynchronous active-high reset
//   i_ex_valid                  the ex_* and mret inputs describe a live instruction
//   i_exceptSignal[6:0]         exception vector (bit 6 breakpoint .. bit 0 load misaligned)
//   i_ex_pc, i_ex_addr          PC and faulting data address of that instruction
//   i_mret                      live mret
//   i_csr_we/addr/wdata         CSR write port
//   o_csr_rdata                 combinational read of the addressed CSR
//   o_flush                     kill younger in-flight instructions
//   o_redirect_valid/pc         one-cycle fetch redirect
//   o_busy                      sequence in progress (not idle)
module trap_ctrl #(
  parameter int unsigned  N            = 64,
  parameter int unsigned  FLUSH_CYCLES = 2,
  parameter logic [N-1:0] MTVEC_RESET  = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ex_valid,
  input  logic [6:0]   i_exceptSignal,
  input  logic [N-1:0] i_ex_pc,
  input  logic [N-1:0] i_ex_addr,
  input  logic         i_mret,
  input  logic         i_csr_we,
  input  logic [11:0]  i_csr_addr,
  input  logic [N-1:0] i_csr_wdata,
  output logic [N-1:0] o_csr_rdata,
  output logic         o_flush,
  output logic         o_redirect_valid,
  output logic [N-1:0] o_redirect_pc,
  output logic         o_busy
);

  localparam logic [11:0] AddrMtvec  = 12'h305;
  localparam logic [11:0] AddrMepc   = 12'h341;
  localparam logic [11:0] AddrMcause = 12'h342;
  localparam logic [11:0] AddrMtval  = 12'h343;
  localparam logic [3:0]  CntInit    = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [N-1:0] r_mtvec, r_mepc, r_mcause, r_mtval, r_target;

  logic         w_trap, w_ret;
  logic [3:0]   w_code;
  logic [N-1:0] w_tval;

  assign w_trap = (r_state == IDLE) && i_ex_valid && (|i_exceptSignal);
  assign w_ret  = (r_state == IDLE) && i_ex_valid && i_mret && !(|i_exceptSignal);

  // Fixed cause priority; only a breakpoint reports the PC in mtval.
  always_comb begin
    w_code = 4'd0;
    w_tval = i_ex_addr;
    if (i_exceptSignal[6]) begin
      w_code = 4'd3;
      w_tval = i_ex_pc;
    end else if (i_exceptSignal[2]) w_code = 4'd6;
    else if (i_exceptSignal[0])    w_code = 4'd4;
    else if (i_exceptSignal[5])    w_code = 4'd15;
    else if (i_exceptSignal[4])    w_code = 4'd13;
    else if (i_exceptSignal[3])    w_code = 4'd7;
    else if (i_exceptSignal[1])    w_code = 4'd5;
  end

  // Reads show the pre-edge value; no write bypass.
  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_addr)
      AddrMtvec:  o_csr_rdata = r_mtvec;
      AddrMepc:   o_csr_rdata = r_mepc;
      AddrMcause: o_csr_rdata = r_mcause;
      AddrMtval:  o_csr_rdata = r_mtval;
      default:    o_csr_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_mtvec          <= MTVEC_RESET;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_target         <= '0;
      o_flush          <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_busy           <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trap) begin
            r_mepc   <= {i_ex_pc[N-1:2], 2'b00};
            r_mcause <= {{(N-4){1'b0}}, w_code};
            r_mtval  <= w_tval;
            r_target <= r_mtvec;
            r_cnt    <= CntInit;
            r_state  <= FLUSH;
            o_flush  <= 1'b1;
            o_busy   <= 1'b1;
          end else if (w_ret) begin
            r_target <= r_mepc;
            r_cnt    <= CntInit;
            r_state  <= FLUSH;
            o_flush  <= 1'b1;
            o_busy   <= 1'b1;
          end else if (i_csr_we) begin
            // Software writes land only on quiet idle cycles.
            case (i_csr_addr)
              AddrMtvec:  r_mtvec  <= {i_csr_wdata[N-1:2], 2'b00};
              AddrMepc:   r_mepc   <= {i_csr_wdata[N-1:2], 2'b00};
              AddrMcause: r_mcause <= i_csr_wdata;
              AddrMtval:  r_mtval  <= i_csr_wdata;
              default: ;
            endcase
          end
        end
        FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state          <= REDIRECT;
            o_flush          <= 1'b0;
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= r_target;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          r_state          <= IDLE;
          o_redirect_valid <= 1'b0;
          o_busy           <= 1'b0;
        end
        default: begin
          r_state          <= IDLE;
          o_flush          <= 1'b0;
          o_redirect_valid <= 1'b0;
          o_busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int unsigned N = 64;
  localparam int unsigned F = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ex_valid = 1'b0;
  logic [6:0]    exc = '0;
  logic [N-1:0]  ex_pc = '0;
  logic [N-1:0]  ex_addr = '0;
  logic          mret = 1'b0;
  logic          csr_we = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [N-1:0]  csr_wdata = '0;
  logic [N-1:0]  csr_rdata;
  logic          flush, redirect_valid, busy;
  logic [N-1:0]  redirect_pc;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  trap_ctrl #(.N(N), .FLUSH_CYCLES(F), .MTVEC_RESET('0)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_ex_valid       (ex_valid),
    .i_exceptSignal   (exc),
    .i_ex_pc          (ex_pc),
    .i_ex_addr        (ex_addr),
    .i_mret           (mret),
    .i_csr_we         (csr_we),
    .i_csr_addr       (csr_addr),
    .i_csr_wdata      (csr_wdata),
    .o_csr_rdata      (csr_rdata),
    .o_flush          (flush),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase = cycles elapsed since acceptance (0 = idle). Flush in 1..F, redirect at F+1.
  localparam int PRI_BIT[7]  = '{6, 2, 0, 5, 4, 3, 1};
  localparam int PRI_CODE[7] = '{3, 6, 4, 15, 13, 7, 5};

  function automatic logic [63:0] model_code(input logic [6:0] e);
    for (int i = 0; i < 7; i++) if (e[PRI_BIT[i]]) return 64'(PRI_CODE[i]);
    return 64'd0;
  endfunction

  int           phase;
  logic [63:0]  m_mtvec, m_mepc, m_mcause, m_mtval, m_target, m_rpc;
  logic         m_trap, m_ret;

  assign m_trap = (phase == 0) && ex_valid && (exc != 7'd0);
  assign m_ret  = (phase == 0) && ex_valid && mret && (exc == 7'd0);

  function automatic logic [63:0] m_csr(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 0;
      m_mtvec <= '0; m_mepc <= '0; m_mcause <= '0; m_mtval <= '0;
      m_target <= '0; m_rpc <= '0;
    end else if (m_trap) begin
      m_mepc   <= {ex_pc[63:2], 2'b00};
      m_mcause <= model_code(exc);
      m_mtval  <= exc[6] ? ex_pc : ex_addr;
      m_target <= m_mtvec;
      phase    <= 1;
    end else if (m_ret) begin
      m_target <= m_mepc;
      phase    <= 1;
    end else if (phase == 0) begin
      if (csr_we) begin
        case (csr_addr)
          12'h305: m_mtvec  <= {csr_wdata[63:2], 2'b00};
          12'h341: m_mepc   <= {csr_wdata[63:2], 2'b00};
          12'h342: m_mcause <= csr_wdata;
          12'h343: m_mtval  <= csr_wdata;
          default: ;
        endcase
      end
    end else if (phase == F + 1) begin
      phase <= 0;
    end else begin
      if (phase == F) m_rpc <= m_target;
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("flush", 64'(flush), 64'(phase >= 1 && phase <= F));
      cmp("redirect_valid", 64'(redirect_valid), 64'(phase == F + 1));
      cmp("busy", 64'(busy), 64'(phase != 0));
      cmp("redirect_pc", redirect_pc, m_rpc);
      cmp("csr_rdata", csr_rdata, m_csr(csr_addr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
    csr_addr = a;
    #1;
    cmp(name, csr_rdata, exp);
  endtask

  task automatic clr();
    ex_valid = 1'b0; exc = '0; mret = 1'b0; csr_we = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // reset state
    cmp("rst_flush", 64'(flush), 64'd0);
    cmp("rst_rv", 64'(redirect_valid), 64'd0);
    cmp("rst_busy", 64'(busy), 64'd0);
    rd("rst_mtvec", 12'h305, 64'h0);

    // mtvec write, low bits forced to zero
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 64'h1003;
    step(); clr();
    rd("mtvec_wr", 12'h305, 64'h1000);

    // store misaligned trap
    ex_valid = 1'b1; exc = 7'b0000100; ex_pc = 64'h2006; ex_addr = 64'h8001;
    step(); clr();
    cmp("trap_flush1", 64'(flush), 64'd1);
    step();
    cmp("trap_flush2", 64'(flush), 64'd1);
    step();
    cmp("trap_rv", 64'(redirect_valid), 64'd1);
    cmp("trap_rpc", redirect_pc, 64'h1000);
    cmp("trap_rv_noflush", 64'(flush), 64'd0);
    step();
    cmp("trap_idle", 64'(busy), 64'd0);
    rd("trap_mepc", 12'h341, 64'h2004);
    rd("trap_mcause", 12'h342, 64'd6);
    rd("trap_mtval", 12'h343, 64'h8001);

    // mret back to mepc, CSRs untouched
    ex_valid = 1'b1; mret = 1'b1;
    step(); clr();
    step(); step();
    cmp("mret_rv", 64'(redirect_valid), 64'd1);
    cmp("mret_rpc", redirect_pc, 64'h2004);
    step();
    rd("mret_mcause", 12'h342, 64'd6);
    rd("mret_mtval", 12'h343, 64'h8001);

    // exception beats mret and the same-cycle CSR write
    ex_valid = 1'b1; mret = 1'b1; exc = 7'b0000001; ex_pc = 64'h3000; ex_addr = 64'h3333;
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 64'h5000;
    step(); clr();
    // during FLUSH: another exception and a CSR write, both ignored
    ex_valid = 1'b1; exc = 7'b0000010; ex_pc = 64'h7000; ex_addr = 64'h7777;
    csr_we = 1'b1; csr_addr = 12'h343; csr_wdata = 64'hdead;
    step(); clr();
    step();
    cmp("both_rv", 64'(redirect_valid), 64'd1);
    cmp("both_rpc", redirect_pc, 64'h1000);
    step();
    rd("both_mcause", 12'h342, 64'd4);
    rd("both_mtval", 12'h343, 64'h3333);
    rd("both_mepc", 12'h341, 64'h3000);
    rd("both_mtvec", 12'h305, 64'h1000);

    // breakpoint has top priority and reports the PC
    ex_valid = 1'b1; exc = 7'b1010101; ex_pc = 64'h40; ex_addr = 64'h9999;
    step(); clr();
    repeat (3) step();
    rd("bp_mcause", 12'h342, 64'd3);
    rd("bp_mtval", 12'h343, 64'h40);

    // mepc write masking and unmapped write
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 64'h123;
    step();
    csr_addr = 12'h300; csr_wdata = 64'hffff;
    step(); clr();
    rd("mepc_mask", 12'h341, 64'h120);
    rd("unmapped", 12'h300, 64'h0);

    // reset in the second flush cycle
    ex_valid = 1'b1; exc = 7'b0000010; ex_pc = 64'h500; ex_addr = 64'h600;
    step(); clr();
    step();
    cmp("pre_rst_flush", 64'(flush), 64'd1);
    #2 reset = 1'b1;
    #1;
    cmp("rst_mid_flush", 64'(flush), 64'd0);
    cmp("rst_mid_busy", 64'(busy), 64'd0);
    rd("rst_mid_mepc", 12'h341, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("post_rst_no_rv", 64'(redirect_valid), 64'd0);
    end
    rd("post_rst_mtvec", 12'h305, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
